// File: rtl/bidir_bus_ctrl.sv
// Direction-sequencing controller for a bidirectional pad bank.
// Converts a write/read command stream into contention-free drive/release
// sequences with programmable turnaround, synchronizes pad input into
// one-shot read responses, and parks (releases) an idle driven bus.
module bidir_bus_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PARK_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_o,
  output logic             pad_t
);

  localparam int MAXC = (TURNAROUND > SYNC_STAGES) ? TURNAROUND : SYNC_STAGES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (PARK_CYCLES > 0) ? $clog2(PARK_CYCLES + 1) : 1;

  localparam logic [CW-1:0] TA_LAST   = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_STAGES - 1);
  localparam logic [PW-1:0] PARK_MAX  = PW'(PARK_CYCLES);

  typedef enum logic [2:0] {
    S_LISTEN,
    S_TA_OUT,
    S_DRIVE,
    S_TA_IN,
    S_SAMPLE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    park_cnt;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic             accept;

  // Command handshake: ready depends on state only.
  always_comb begin
    cmd_ready = (state == S_LISTEN) || (state == S_DRIVE);
    accept    = cmd_valid && cmd_ready;
  end

  // Free-running pad input synchronizer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < unsigned'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int unsigned i = 1; i < unsigned'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Direction FSM with registered pad and response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_LISTEN;
      cnt       <= '0;
      park_cnt  <= '0;
      wdata     <= '0;
      pad_t     <= 1'b1;
      pad_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_LISTEN: begin
          if (accept) begin
            cnt <= '0;
            if (cmd_write) begin
              // Held aside so pad_o keeps its old value while still released.
              wdata    <= cmd_data;
              park_cnt <= '0;
              state    <= S_TA_OUT;
            end else begin
              state <= S_SAMPLE;
            end
          end
        end
        S_TA_OUT: begin
          if (cnt == TA_LAST) begin
            pad_o <= wdata;
            pad_t <= 1'b0;
            state <= S_DRIVE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRIVE: begin
          // An accepted command takes priority over the park timeout.
          if (accept) begin
            if (cmd_write) begin
              pad_o    <= cmd_data;
              park_cnt <= '0;
            end else begin
              pad_t <= 1'b1;
              cnt   <= '0;
              state <= S_TA_IN;
            end
          end else if (PARK_CYCLES != 0) begin
            if (park_cnt == PARK_MAX) begin
              pad_t <= 1'b1;
              state <= S_LISTEN;
            end else begin
              park_cnt <= park_cnt + PW'(1);
            end
          end
        end
        S_TA_IN: begin
          if (cnt == TA_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          if (cnt == SYNC_LAST) begin
            rsp_data  <= sync_q[SYNC_STAGES-1];
            rsp_valid <= 1'b1;
            state     <= S_LISTEN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          pad_t <= 1'b1;
          state <= S_LISTEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed self-checking bench for bidir_bus_ctrl (default parameters:
// WIDTH=8, TURNAROUND=2, SYNC_STAGES=2, PARK_CYCLES=16).
module tb_bidir_bus_ctrl;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] pad_i;
  logic [7:0] pad_o;
  logic       pad_t;

  int vectors;
  int miscompares;

  bidir_bus_ctrl #(
    .WIDTH      (8),
    .TURNAROUND (2),
    .SYNC_STAGES(2),
    .PARK_CYCLES(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .pad_i    (pad_i),
    .pad_o    (pad_o),
    .pad_t    (pad_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen 1ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_pad_t"}, 32'(pad_t), 32'h1);
    check({tag, "_pad_o"}, 32'(pad_o), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_data    = 8'h00;
    pad_i       = 8'h00;
    step();
    step();
    reset = 1'b0;
    step();
    idle_check("reset");
    check("reset_rsp_data", 32'(rsp_data), 32'h0);

    // Write 0xA5 from LISTEN; hold a read offer through the turnaround.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'hA5;
    step();                                 // cycle k+1
    cmd_write = 1'b0; cmd_data = 8'hFF;     // still valid: must be ignored
    check("wr_k1_pad_t", 32'(pad_t), 32'h1);
    check("wr_k1_pad_o_held", 32'(pad_o), 32'h0);
    check("wr_k1_ready", 32'(cmd_ready), 32'h0);
    step();                                 // k+2
    check("wr_k2_pad_t", 32'(pad_t), 32'h1);
    check("wr_k2_ready", 32'(cmd_ready), 32'h0);
    step();                                 // k+3
    check("wr_k3_pad_t", 32'(pad_t), 32'h0);
    check("wr_k3_pad_o", 32'(pad_o), 32'hA5);
    check("wr_k3_ready", 32'(cmd_ready), 32'h1);

    // Write 0x3C in DRIVE: lands next cycle with no drive gap.
    cmd_write = 1'b1; cmd_data = 8'h3C;
    step();
    cmd_valid = 1'b0;
    check("wr_drive_pad_o", 32'(pad_o), 32'h3C);
    check("wr_drive_pad_t", 32'(pad_t), 32'h0);

    // Read from DRIVE with pad_i=0x5A; alternate offers while not ready.
    pad_i = 8'h5A;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    step();                                 // k+1
    for (int c = 1; c <= 4; c++) begin
      cmd_write = (c % 2 == 1); cmd_data = 8'hFF;
      check($sformatf("rd_drv_k%0d_pad_t", c), 32'(pad_t), 32'h1);
      check($sformatf("rd_drv_k%0d_ready", c), 32'(cmd_ready), 32'h0);
      check($sformatf("rd_drv_k%0d_rsp_valid", c), 32'(rsp_valid), 32'h0);
      if (c == 4) cmd_valid = 1'b0;
      step();
    end
    check("rd_drv_k5_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_drv_k5_rsp_data", 32'(rsp_data), 32'h5A);
    check("rd_drv_k5_ready", 32'(cmd_ready), 32'h1);
    check("rd_drv_k5_pad_t", 32'(pad_t), 32'h1);
    step();
    check("rd_drv_k6_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rd_drv_k6_rsp_data_hold", 32'(rsp_data), 32'h5A);
    check("rd_drv_k6_pad_t", 32'(pad_t), 32'h1);
    check("rd_drv_k6_pad_o_hold", 32'(pad_o), 32'h3C);

    // Back-to-back reads from LISTEN.
    pad_i = 8'hC3;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    step();                                 // k+1
    cmd_valid = 1'b0;
    check("rd_ls_k1_ready", 32'(cmd_ready), 32'h0);
    step();                                 // k+2
    check("rd_ls_k2_rsp_valid", 32'(rsp_valid), 32'h0);
    step();                                 // k+3
    check("rd_ls_k3_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_ls_k3_rsp_data", 32'(rsp_data), 32'hC3);
    check("rd_ls_k3_ready", 32'(cmd_ready), 32'h1);
    pad_i = 8'h96;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("rd_b2b_k1_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    step();
    check("rd_b2b_k3_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_b2b_k3_rsp_data", 32'(rsp_data), 32'h96);

    // Park: write 0x11, DRIVE entry at k+3, release 17 cycles after entry.
    step();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h11;
    step();
    cmd_valid = 1'b0;
    step();
    step();                                 // DRIVE entry d
    check("park_entry_pad_t", 32'(pad_t), 32'h0);
    for (int c = 0; c < 16; c++) step();    // d+16
    check("park_d16_pad_t", 32'(pad_t), 32'h0);
    step();                                 // d+17
    check("park_d17_pad_t", 32'(pad_t), 32'h1);
    check("park_d17_ready", 32'(cmd_ready), 32'h1);
    check("park_d17_pad_o_hold", 32'(pad_o), 32'h11);

    // Park with a write on the timeout edge: stays DRIVE, counter restarts.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h22;
    step();
    cmd_valid = 1'b0;
    step();
    step();                                 // d
    for (int c = 0; c < 16; c++) step();    // d+16
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h33;
    step();                                 // d+17
    cmd_valid = 1'b0;
    check("park_rst_pad_t", 32'(pad_t), 32'h0);
    check("park_rst_pad_o", 32'(pad_o), 32'h33);
    for (int c = 0; c < 16; c++) step();    // d+33
    check("park_rst_d33_pad_t", 32'(pad_t), 32'h0);
    step();                                 // d+34
    check("park_rst_d34_pad_t", 32'(pad_t), 32'h1);

    // Reset during TA_OUT: async recovery, then no drive ever appears.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h77;
    step();
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    idle_check("rst_ta_out_async");
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rst_ta_out_nodrive%0d", c), 32'(pad_t), 32'h1);
    end
    check("rst_ta_out_ready", 32'(cmd_ready), 32'h1);

    // Reset during SAMPLE: response abandoned.
    pad_i = 8'hEE;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_sample_norsp%0d", c), 32'(rsp_valid), 32'h0);
    end
    check("rst_sample_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_sample_ready", 32'(cmd_ready), 32'h1);
    check("rst_sample_pad_t", 32'(pad_t), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
